img_flow_sequencer: RTL

Drives the 22-bit read index of the image-flow stimulus memory and turns its 34-bit words into a valid/ready stream for the block-matching array.
- Word format: data[33:2] pixel payload, data[1] init, data[0] rst_n.
- Walks the memory from 0 to a programmable last index and absorbs downstream backpressure in a 2-entry output FIFO.
- Provides start, abort and done control to the testbench top level.

---
 rtl/img_flow_sequencer_pkg.sv | 35 +++
 rtl/img_flow_sequencer_fifo.sv | 73 +++++++
 rtl/img_flow_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/img_flow_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : img_flow_pkg
// Description : Shared constants and types for the image-flow stimulus
//               sequencer: memory index / word widths, word field positions,
//               the sequencer state encoding and the unpacked word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package img_flow_pkg;

  localparam int ADDR_W     = 22;          // memory index width
  localparam int WORD_W     = 34;          // memory word width
  localparam int PIX_W      = WORD_W - 2;  // pixel payload width
  localparam int WORDS_W    = ADDR_W + 1;  // holds 2^ADDR_W accepted words
  localparam int INIT_BIT   = 1;
  localparam int RSTN_BIT   = 0;
  localparam int FIFO_DEPTH = 2;           // output buffer entries

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  // Field order matches the memory word: pixel in [33:2], init in [1],
  // rst_n in [0], so a plain cast converts between the two.
  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic             init;
    logic             rst_n;
  } img_word_t;

endpackage : img_flow_pkg
`default_nettype wire

// File: rtl/img_flow_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flow_fifo2
// Description : Two-entry output buffer built as a head register plus a tail
//               register. The head register drives the outputs directly, so
//               there is no combinational path from din_i to head_o.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               clr_i         - synchronous flush (occupancy to zero)
//               push_i, din_i - write a word
//               pop_i         - consume the head word
//               head_o        - head word (registered)
//               valid_o       - head word present
//               full_o        - both entries occupied
// Revision    : 1.0 - initial release
// ============================================================================
module flow_fifo2
  import img_flow_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_i,
  input  logic      push_i,
  input  img_word_t din_i,
  input  logic      pop_i,
  output img_word_t head_o,
  output logic      valid_o,
  output logic      full_o
);

  img_word_t  head_q;
  img_word_t  tail_q;
  logic [1:0] occ_q;

  assign head_o  = head_q;
  assign valid_o = (occ_q != 2'd0);
  assign full_o  = (occ_q == 2'(FIFO_DEPTH));

  // The caller never pops when empty nor pushes when full without a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (clr_i) begin
      occ_q <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= din_i;
          else               tail_q <= din_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          // With one entry the head simply goes invalid; copying the stale
          // tail is harmless and keeps the mux small.
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din_i;
          end else begin
            head_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : flow_fifo2
`default_nettype wire

// File: rtl/img_flow_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : img_flow_sequencer
// Description : Walks the image-flow stimulus memory from index 0 to a
//               programmable last index and presents each 34-bit word as a
//               valid/ready stream (pixel, init, rst_n) through a 2-entry
//               buffer that absorbs downstream backpressure.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start, abort       - frame control pulses (abort wins)
//               cfg_last           - last index, sampled on accepted start
//               count / mem_data   - memory index out, word back (same cycle)
//               out_valid/out_ready, out_pixel/out_init/out_rst_n - stream
//               busy, done         - RUN/DRAIN status, end-of-frame pulse
//               words_out          - words accepted downstream this frame
// Config      : FRAME_LOOP_EN - when defined, the index wraps from last back
//               to 0 and the frame loops until aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module img_flow_sequencer
  import img_flow_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  cfg_last,
  output logic [ADDR_W-1:0]  count,
  input  logic [WORD_W-1:0]  mem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_init,
  output logic               out_rst_n,
  output logic               busy,
  output logic               done,
  output logic [WORDS_W-1:0] words_out
);

  fsm_state_t         state_q;
  logic [ADDR_W-1:0]  count_q;
  logic [ADDR_W-1:0]  last_q;
  logic [WORDS_W-1:0] words_q;
  logic               busy_q;
  logic               done_q;

  img_word_t fifo_din;
  img_word_t fifo_head;
  logic      fifo_valid;
  logic      fifo_full;
  logic      pop;
  logic      issue;
  logic      flush;

  assign fifo_din = img_word_t'(mem_data);
  assign pop      = fifo_valid & out_ready;
  assign flush    = abort & ((state_q == RUN) | (state_q == DRAIN));
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign issue    = (state_q == RUN) & ~abort & (~fifo_full | pop);

  flow_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (issue),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= '0;
      words_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A pop in the abort cycle still delivered its word, so it is counted.
      if (pop) words_q <= words_q + WORDS_W'(1);
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            last_q  <= cfg_last;
            count_q <= '0;
            words_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (issue) begin
            if (count_q == last_q) begin
`ifdef FRAME_LOOP_EN
              count_q <= '0;
`else
              // Index holds at last so a full-range frame never wraps.
              state_q <= DRAIN;
`endif
            end else begin
              count_q <= count_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (pop && !fifo_full) begin
            // No pushes in DRAIN, so a pop while not full empties the buffer.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count     = count_q;
  assign out_valid = fifo_valid;
  assign out_pixel = fifo_head.pixel;
  assign out_init  = fifo_head.init;
  assign out_rst_n = fifo_head.rst_n;
  assign busy      = busy_q;
  assign done      = done_q;
  assign words_out = words_q;

endmodule : img_flow_sequencer
`default_nettype wire
